// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake, flush-to-bubble and occupancy count.
// Optional skid entry (registered in_ready, full throughput) enabled by PIPE_STAGE_SKID_EN.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RST_VAL   = '0,
  parameter logic [WIDTH-1:0] FLUSH_VAL = WIDTH'(32'h0000_0013)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  localparam int unsigned CW = 2;

  logic             in_xfer;
  logic             out_xfer;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    count_q, count_d;

`ifdef PIPE_STAGE_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;

  // Ready depends only on registered skid occupancy, never on out_ready.
  assign in_ready = rst & ~flush & ~skid_valid_q;
`else
  assign in_ready = rst & ~flush & (~valid_q | out_ready);
`endif

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = valid_q & out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign count     = count_q;

  // Next-state: reset beats flush beats normal handshake traffic.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
`endif
    if (!rst) begin
      valid_d = 1'b0;
      data_d  = RST_VAL;
`ifdef PIPE_STAGE_SKID_EN
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
`endif
    end else if (flush) begin
      valid_d = 1'b0;
      data_d  = FLUSH_VAL;
`ifdef PIPE_STAGE_SKID_EN
      skid_valid_d = 1'b0;
`endif
    end else begin
`ifdef PIPE_STAGE_SKID_EN
      if (out_xfer && skid_valid_q) begin
        // Pop skid into main to keep FIFO order; a concurrent input refills skid.
        data_d       = skid_data_q;
        skid_valid_d = in_xfer;
        if (in_xfer) begin
          skid_data_d = in_data;
        end
      end else if (in_xfer && valid_q && !out_xfer) begin
        skid_data_d  = in_data;
        skid_valid_d = 1'b1;
      end else if (in_xfer) begin
        data_d  = in_data;
        valid_d = 1'b1;
      end else if (out_xfer) begin
        valid_d = 1'b0;
      end
`else
      if (in_xfer) begin
        data_d  = in_data;
        valid_d = 1'b1;
      end else if (out_xfer) begin
        valid_d = 1'b0;
      end
`endif
    end
`ifdef PIPE_STAGE_SKID_EN
    count_d = CW'(valid_d) + CW'(skid_valid_d);
`else
    count_d = CW'(valid_d);
`endif
  end

  // Reset and flush are folded into the next-state logic, so this is a plain register bank.
  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    data_q  <= data_d;
    count_q <= count_d;
`ifdef PIPE_STAGE_SKID_EN
    skid_valid_q <= skid_valid_d;
    skid_data_q  <= skid_data_d;
`endif
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; expectations follow PIPE_STAGE_SKID_EN when defined.
module tb_pipe_stage_reg;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_stage_reg #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] d, input logic [1:0] c);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_count"}, 32'(count), 32'(c));
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEADBEEF;
    out_ready = 1'b1;

    // Reset held two cycles with valid input present
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_out("reset", 1'b0, 32'h0, 2'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd0);
    end

    // Streaming 1..4 at full rate
    rst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 32'(i);
      #1;
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk_out("stream", 1'b1, 32'(i), 2'd1);
    end
    in_valid = 1'b0;
    in_data  = 32'hFFFF_FFFF;
    tick();
    chk_out("stream_drain", 1'b0, 32'd4, 2'd0);

    // Stall with pending input
    in_valid = 1'b1;
    in_data  = 32'hA5A5A5A5;
    tick();
    chk_out("stall_load", 1'b1, 32'hA5A5A5A5, 2'd1);
    out_ready = 1'b0;
    in_data   = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      #1;
`ifdef PIPE_STAGE_SKID_EN
      chk("stall_in_ready", 32'(in_ready), (i == 0) ? 32'd1 : 32'd0);
      tick();
      chk_out("stall_hold", 1'b1, 32'hA5A5A5A5, 2'd2);
`else
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk_out("stall_hold", 1'b1, 32'hA5A5A5A5, 2'd1);
`endif
    end
    out_ready = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
    in_valid = 1'b0;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk_out("release_first", 1'b1, 32'h11111111, 2'd1);
`else
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk_out("release_first", 1'b1, 32'h11111111, 2'd1);
    in_valid = 1'b0;
`endif
    tick();
    chk_out("release_empty", 1'b0, 32'h11111111, 2'd0);

    // Flush while full drops the presented input
    in_valid  = 1'b1;
    in_data   = 32'h00500093;
    out_ready = 1'b0;
    tick();
    chk_out("flush_full", 1'b1, 32'h00500093, 2'd1);
    flush   = 1'b1;
    in_data = 32'h00100113;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk_out("flush", 1'b0, 32'h00000013, 2'd0);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk_out("flush_after", 1'b0, 32'h00000013, 2'd0);

    // Reset during a stall discards held entries
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = 32'hAAAA0000;
    tick();
    in_data = 32'hBBBB0000;
    tick();
`ifdef PIPE_STAGE_SKID_EN
    chk_out("midstall_full", 1'b1, 32'hAAAA0000, 2'd2);
`else
    chk_out("midstall_full", 1'b1, 32'hAAAA0000, 2'd1);
`endif
    rst = 1'b0;
    tick();
    chk_out("midstall_reset", 1'b0, 32'h0, 2'd0);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk_out("midstall_after", 1'b0, 32'h0, 2'd0);

    // Single-item drain; out_data keeps the last value
    in_valid  = 1'b1;
    in_data   = 32'd7;
    out_ready = 1'b0;
    tick();
    chk_out("drain_load", 1'b1, 32'd7, 2'd1);
    in_valid  = 1'b0;
    in_data   = 32'h0000FFFF;
    out_ready = 1'b1;
    tick();
    chk_out("drain", 1'b0, 32'd7, 2'd0);
    tick();
    chk_out("drain_idle", 1'b0, 32'd7, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
